// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results into one in-order register-file write port.
// Define WB_QUEUE_FWD_EN to compile in read-port forwarding from pending writes.
module wb_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_reg,
    input  logic [31:0]                mem_data,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_reg,
    input  logic [31:0]                alu_data,
    output logic                       in_ready,
    output logic                       wEn,
    output logic [4:0]                 wReg,
    output logic [31:0]                wData,
    input  logic [4:0]                 Reg0,
    input  logic [4:0]                 Reg1,
    output logic                       fwd0_hit,
    output logic                       fwd1_hit,
    output logic [31:0]                fwd0_data,
    output logic [31:0]                fwd1_data,
    output logic [$clog2(DEPTH):0]     pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    ent_reg_q  [DEPTH];
    logic [4:0]    ent_reg_d  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic          wen_q, wen_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          mem_push, alu_push, pop;
    logic [AW-1:0] alu_slot;

    // Ready needs room for two entries so both sources can always push together.
    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(2);
    assign mem_push = mem_valid && in_ready && (mem_reg != 5'd0);
    assign alu_push = alu_valid && in_ready && (alu_reg != 5'd0);
    assign pop      = (count_q != '0);
    assign alu_slot = wr_ptr_q + AW'(mem_push);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q + AW'(mem_push) + AW'(alu_push);
        count_d    = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        wen_d      = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (pop) begin
            wen_d    = 1'b1;
            wreg_d   = ent_reg_q[rd_ptr_q];
            wdata_d  = ent_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (mem_push) begin
            ent_reg_d[wr_ptr_q]  = mem_reg;
            ent_data_d[wr_ptr_q] = mem_data;
        end
        if (alu_push) begin
            ent_reg_d[alu_slot]  = alu_reg;
            ent_data_d[alu_slot] = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        ent_reg_q  <= ent_reg_d;
        ent_data_q <= ent_data_d;
    end

    assign wEn     = wen_q;
    assign wReg    = wreg_q;
    assign wData   = wdata_q;
    assign pending = count_q;

`ifdef WB_QUEUE_FWD_EN
    logic          f0_hit, f1_hit;
    logic [31:0]   f0_data, f1_data;
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        f0_hit  = 1'b0;
        f1_hit  = 1'b0;
        f0_data = '0;
        f1_data = '0;
        fwd_idx = '0;
        if (wen_q && Reg0 != 5'd0 && wreg_q == Reg0) begin
            f0_hit  = 1'b1;
            f0_data = wdata_q;
        end
        if (wen_q && Reg1 != 5'd0 && wreg_q == Reg1) begin
            f1_hit  = 1'b1;
            f1_data = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if (Reg0 != 5'd0 && ent_reg_q[fwd_idx] == Reg0) begin
                    f0_hit  = 1'b1;
                    f0_data = ent_data_q[fwd_idx];
                end
                if (Reg1 != 5'd0 && ent_reg_q[fwd_idx] == Reg1) begin
                    f1_hit  = 1'b1;
                    f1_data = ent_data_q[fwd_idx];
                end
            end
        end
    end

    assign fwd0_hit  = f0_hit;
    assign fwd1_hit  = f1_hit;
    assign fwd0_data = f0_data;
    assign fwd1_data = f1_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{Reg0, Reg1};
    assign fwd0_hit   = 1'b0;
    assign fwd1_hit   = 1'b0;
    assign fwd0_data  = '0;
    assign fwd1_data  = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed steps, a reference occupancy model and
// an in-order scoreboard of expected register-file writes.
module tb_wb_queue;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_valid = 1'b0, alu_valid = 1'b0;
  logic [4:0] mem_reg = '0, alu_reg = '0, Reg0 = '0, Reg1 = '0;
  logic [31:0] mem_data = '0, alu_data = '0;
  logic in_ready, wEn, fwd0_hit, fwd1_hit;
  logic [4:0] wReg;
  logic [31:0] wData, fwd0_data, fwd1_data;
  logic [$clog2(DEPTH):0] pending;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .in_ready(in_ready), .wEn(wEn), .wReg(wReg), .wData(wData),
    .Reg0(Reg0), .Reg1(Reg1),
    .fwd0_hit(fwd0_hit), .fwd1_hit(fwd1_hit),
    .fwd0_data(fwd0_data), .fwd1_data(fwd1_data),
    .pending(pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int w_seen = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: occupancy, ready, output-register timing, expected writes
  logic [36:0] exp_q[$];
  int m_cnt = 0;
  logic m_wen = 1'b0;
  logic m_rdy, acc_m, acc_a;
  assign m_rdy = (DEPTH - m_cnt) >= 2;
  assign acc_m = m_rdy && mem_valid && (mem_reg != 5'd0);
  assign acc_a = m_rdy && alu_valid && (alu_reg != 5'd0);

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt <= 0;
      m_wen <= 1'b0;
    end else begin
      if (acc_m) exp_q.push_back({mem_reg, mem_data});
      if (acc_a) exp_q.push_back({alu_reg, alu_data});
      m_cnt <= m_cnt + int'(acc_m) + int'(acc_a) - int'(m_cnt != 0);
      m_wen <= (m_cnt != 0);
    end
  end

  // scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wen_timing", 37'(wEn), 37'(m_wen));
      chk("pending", 37'(pending), 37'(m_cnt));
      chk("in_ready", 37'(in_ready), 37'(m_rdy));
`ifndef WB_QUEUE_FWD_EN
      chk("fwd_tied0", {3'b0, fwd0_hit, fwd1_hit, fwd0_data | fwd1_data}, 37'd0);
`endif
      if (wEn === 1'b1) begin
        w_seen++;
        if (exp_q.size() > 0) begin
          chk("write", {wReg, wData}, exp_q.pop_front());
        end else begin
          chk_cnt++;
          $error("FAIL write_unexpected: observed %h expected none", {wReg, wData});
        end
      end
    end
  end

  logic [4:0] mr[16], ar[16];
  logic [31:0] md[16], ad[16];
  int mi, ai, w0, lim;
  bit saw_full, rdy_now;

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_pending", 37'(pending), 37'd0);
    chk("rst_wen", 37'(wEn), 37'd0);
    chk("rst_wout", {wReg, wData}, 37'd0);
    chk("rst_in_ready", 37'(in_ready), 37'd1);
    chk("rst_fwd", {3'b0, fwd0_hit, fwd1_hit, fwd0_data | fwd1_data}, 37'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // single alu push: write two cycles later, exactly one cycle
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0;
    chk("single_pending1", 37'(pending), 37'd1);
    chk("single_wen_early", 37'(wEn), 37'd0);
    tick();
    chk("single_write", {wEn, wReg, wData}, {1'b1, 5'd5, 32'h55});
    chk("single_pending0", 37'(pending), 37'd0);
    tick();
    chk("single_wen_once", 37'(wEn), 37'd0);

    // dual push to the same register: mem older, alu younger
    mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'hA;
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hB;
    Reg0 = 5'd3; Reg1 = 5'd3;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
`ifdef WB_QUEUE_FWD_EN
    chk("dual_fwd0_q", {fwd0_hit, fwd0_data}, {1'b1, 32'hB});
`else
    chk("dual_fwd0_q", {fwd0_hit, fwd0_data}, 33'd0);
`endif
    tick();
    chk("dual_write_a", {wEn, wReg, wData}, {1'b1, 5'd3, 32'hA});
`ifdef WB_QUEUE_FWD_EN
    chk("dual_fwd0_mix", {fwd0_hit, fwd0_data}, {1'b1, 32'hB});
`else
    chk("dual_fwd0_mix", {fwd0_hit, fwd0_data}, 33'd0);
`endif
    tick();
    chk("dual_write_b", {wEn, wReg, wData}, {1'b1, 5'd3, 32'hB});
`ifdef WB_QUEUE_FWD_EN
    chk("dual_fwd1_out", {fwd1_hit, fwd1_data}, {1'b1, 32'hB});
`else
    chk("dual_fwd1_out", {fwd1_hit, fwd1_data}, 33'd0);
`endif
    tick();
    chk("dual_fwd0_gone", 37'(fwd0_hit), 37'd0);
    Reg0 = 5'd0; Reg1 = 5'd0;

    // reg 0 request is accepted and dropped
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hDEAD;
    tick();
    mem_valid = 1'b0;
    chk("reg0_pending", 37'(pending), 37'd0);
    chk("reg0_fwd", 37'(fwd0_hit), 37'd0);
    repeat (3) tick();

    // continuous dual stream across pointer wrap; sources hold while not ready
    for (int i = 0; i < 16; i++) begin
      mr[i] = 5'($urandom_range(1, 31)); md[i] = $urandom;
      ar[i] = 5'($urandom_range(1, 31)); ad[i] = $urandom;
    end
    mi = 0; ai = 0; saw_full = 1'b0; w0 = w_seen; lim = 0;
    while ((mi < 16 || ai < 16) && lim < 200) begin
      mem_valid = (mi < 16); mem_reg = mr[mi < 16 ? mi : 0]; mem_data = md[mi < 16 ? mi : 0];
      alu_valid = (ai < 16); alu_reg = ar[ai < 16 ? ai : 0]; alu_data = ad[ai < 16 ? ai : 0];
      rdy_now = m_rdy;
      if (!m_rdy) saw_full = 1'b1;
      tick();
      if (rdy_now) begin
        if (mi < 16) mi++;
        if (ai < 16) ai++;
      end
      lim++;
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("stream_accepted", 37'(mi + ai), 37'd32);
    chk("stream_saw_full", 37'(saw_full), 37'd1);
    repeat (12) tick();
    chk("stream_writes", 37'(w_seen - w0), 37'd32);

    // random traffic including reg 0 and dropped-while-not-ready requests
    for (int i = 0; i < 60; i++) begin
      mem_valid = 1'($urandom_range(0, 1)); mem_reg = 5'($urandom_range(0, 31)); mem_data = $urandom;
      alu_valid = 1'($urandom_range(0, 1)); alu_reg = 5'($urandom_range(0, 31)); alu_data = $urandom;
      tick();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    repeat (12) tick();

    // fill to six then reset with pushes present in the reset cycle
    mem_valid = 1'b1; mem_reg = 5'd7; mem_data = 32'h7;
    alu_valid = 1'b1; alu_reg = 5'd8; alu_data = 32'h8;
    lim = 0;
    while (m_cnt < 6 && lim < 20) begin
      tick();
      lim++;
    end
    chk("fill_pending6", 37'(pending), 37'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    chk("midrst_pending", 37'(pending), 37'd0);
    chk("midrst_wen", 37'(wEn), 37'd0);
    chk("midrst_in_ready", 37'(in_ready), 37'd1);
    repeat (12) tick();

    chk("sb_drained", 37'(exp_q.size()), 37'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
